// File: rtl/instruction_decode_pkg.sv
// Shared types for the decode stage: opcodes, FSM states, ID/EX buffer layout
// and instruction field positions.
package instruction_decode_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int PC_WIDTH   = 24;
    localparam int REG_AW     = 4;
    localparam int INSTR_W    = 32;
    localparam int IF_WIDTH   = INSTR_W + PC_WIDTH;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ALU   = 4'd1,
        OP_ALUI  = 4'd2,
        OP_LOAD  = 4'd3,
        OP_STORE = 4'd4,
        OP_BEQ   = 4'd5,
        OP_BNE   = 4'd6,
        OP_JMP   = 4'd7,
        OP_HALT  = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } id_state_e;

    typedef struct packed {
        logic                  valid;
        opcode_e               op;
        logic [3:0]            funct;
        logic [REG_AW-1:0]     rd;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] imm;
        logic [PC_WIDTH-1:0]   pc;
    } idex_t;

    // Undefined opcodes 9-F behave exactly like NOP.
    function automatic opcode_e decode_op(input logic [3:0] raw);
        return (raw > 4'd8) ? OP_NOP : opcode_e'(raw);
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Decode-stage bus: IF/ID input, register file read port, fetch control and ID/EX output.
interface instruction_decode_if;
    import instruction_decode_pkg::*;

    logic [IF_WIDTH-1:0]   ifBuffer;
    logic [REG_AW-1:0]     rs1Addr;
    logic [REG_AW-1:0]     rs2Addr;
    logic [DATA_WIDTH-1:0] rs1Data;
    logic [DATA_WIDTH-1:0] rs2Data;
    logic                  fetchEn;
    logic                  branchFlag;
    logic [DATA_WIDTH-1:0] branchAddr;
    idex_t                 idexBuffer;

    modport slave (
        input  ifBuffer, rs1Data, rs2Data,
        output rs1Addr, rs2Addr, fetchEn, branchFlag, branchAddr, idexBuffer
    );

    modport master (
        output ifBuffer, rs1Data, rs2Data,
        input  rs1Addr, rs2Addr, fetchEn, branchFlag, branchAddr, idexBuffer
    );

endinterface

// File: rtl/instruction_decode_hazard.sv
// Combinational stall detection: load-use and producer-to-branch-compare dependencies
// against the instruction currently held in ID/EX.
module instruction_decode_hazard
    import instruction_decode_pkg::*;
(
    input  opcode_e           cur_op,
    input  logic [REG_AW-1:0] cur_rs1,
    input  logic [REG_AW-1:0] cur_rs2,
    input  logic              idex_valid,
    input  opcode_e           idex_op,
    input  logic [REG_AW-1:0] idex_rd,
    output logic              stall
);
    logic use_rs1;
    logic use_rs2;
    logic rs1_hit;
    logic rs2_hit;
    logic cur_branch;
    logic load_use;
    logic branch_use;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (cur_op)
            OP_ALU, OP_BEQ, OP_BNE, OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_ALUI, OP_LOAD: use_rs1 = 1'b1;
            default: ;
        endcase

        cur_branch = (cur_op == OP_BEQ) || (cur_op == OP_BNE);
        rs1_hit    = (cur_rs1 == idex_rd);
        rs2_hit    = (cur_rs2 == idex_rd);

        load_use   = (idex_op == OP_LOAD) &&
                     ((use_rs1 && rs1_hit) || (use_rs2 && rs2_hit));
        // Branch compare happens in decode, so any in-flight result is too late for it.
        branch_use = ((idex_op == OP_ALU) || (idex_op == OP_ALUI) || (idex_op == OP_LOAD)) &&
                     cur_branch && (rs1_hit || rs2_hit);

        stall      = idex_valid && (idex_rd != '0) && (load_use || branch_use);
    end

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: operand read, branch resolution, hazard stall, wrong-path squash and
// the ID/EX pipeline register.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    instruction_decode_if.slave id_bus
);
    logic [INSTR_W-1:0]    instr;
    logic [PC_WIDTH-1:0]   pc;
    opcode_e               op;
    logic [DATA_WIDTH-1:0] imm;
    logic [PC_WIDTH-1:0]   target;
    logic                  operands_eq;
    logic                  taken;
    logic                  is_branch;
    logic                  stall;
    idex_t                 decoded;

    id_state_e             state_q;
    id_state_e             state_d;
    idex_t                 idex_q;
    idex_t                 idex_d;

    logic                  fetch_en;
    logic                  branch_flag;
    logic [DATA_WIDTH-1:0] branch_addr;

    assign instr = id_bus.ifBuffer[IF_WIDTH-1 -: INSTR_W];
    assign pc    = id_bus.ifBuffer[PC_WIDTH-1:0];
    assign op    = decode_op(instr[OP_MSB:OP_LSB]);

    assign id_bus.rs1Addr = instr[RS1_MSB:RS1_LSB];
    assign id_bus.rs2Addr = instr[RS2_MSB:RS2_LSB];

    always_comb begin
        if (op == OP_JMP) begin
            imm    = {8'b0, instr[23:0]};
            target = instr[23:0];
        end else begin
            imm    = {{16{instr[15]}}, instr[15:0]};
            target = pc + {{8{instr[15]}}, instr[15:0]};
        end

        operands_eq = (id_bus.rs1Data == id_bus.rs2Data);
        is_branch   = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
        taken       = (op == OP_JMP) ||
                      ((op == OP_BEQ) && operands_eq) ||
                      ((op == OP_BNE) && !operands_eq);

        decoded       = '0;
        decoded.valid = 1'b1;
        decoded.op    = op;
        decoded.funct = instr[3:0];
        decoded.rd    = instr[RD_MSB:RD_LSB];
        decoded.a     = id_bus.rs1Data;
        decoded.b     = id_bus.rs2Data;
        decoded.imm   = imm;
        decoded.pc    = pc;
    end

    instruction_decode_hazard u_hazard (
        .cur_op     (op),
        .cur_rs1    (instr[RS1_MSB:RS1_LSB]),
        .cur_rs2    (instr[RS2_MSB:RS2_LSB]),
        .idex_valid (idex_q.valid),
        .idex_op    (idex_q.op),
        .idex_rd    (idex_q.rd),
        .stall      (stall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            idex_q  <= '0;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (stall)
                    state_d = ST_RUN;
                else if (op == OP_HALT)
                    state_d = ST_HALT;
                else if (taken)
                    state_d = ST_FLUSH;
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    // Everything not explicitly issued below leaves ID/EX as an all-zero bubble.
    always_comb begin
        fetch_en    = 1'b1;
        branch_flag = 1'b0;
        branch_addr = '0;
        idex_d      = '0;
        if (rst) begin
            case (state_q)
                ST_RUN: begin
                    if (stall) begin
                        fetch_en = 1'b0;
                    end else if (op == OP_HALT) begin
                        idex_d = '0;
                    end else if (taken) begin
                        branch_flag = 1'b1;
                        branch_addr = {8'b0, target};
                    end else if (!is_branch) begin
                        idex_d = decoded;
                    end
                end
                ST_HALT:  fetch_en = 1'b0;
                default:  ;
            endcase
        end
    end

    assign id_bus.fetchEn    = fetch_en;
    assign id_bus.branchFlag = branch_flag;
    assign id_bus.branchAddr = branch_addr;
    assign id_bus.idexBuffer = idex_q;

endmodule
